hilo_muldiv: RTL and testbench

Iterative multiply/divide unit with the architectural HI/LO registers, sitting beside the ALU in the execute stage.
- Consumes the same decoded function code (FUN) and operand pair (opA, opB) as the ALU, for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Its hi/lo outputs feed the ALU's opA mux for MFHI/MFLO.
- Asserts busy so the pipeline control stalls until HI/LO are valid.

---
 rtl/hilo_muldiv.sv | 202 ++++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative multiply/divide unit holding the architectural HI/LO
// registers. It sits beside the ALU in the execute stage and is driven by the
// same decoded function code and operand pair.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted only when idle and not flushed
//   funct  in   FUN code (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//   opA    in   multiplicand / dividend / MTHI-MTLO source
//   opB    in   multiplier / divisor
//   flush  in   abort the in-flight operation, HI/LO untouched
//   busy   out  operation in flight; HI/LO reads must stall
//   done   out  one-cycle pulse, new HI/LO visible in this cycle
//   hi     out  HI register
//   lo     out  LO register
//
// Build option: define HILO_FAST_MULT_EN to compute MULT/MULTU with a single
// combinational multiplier at acceptance (busy for one cycle). Without it all
// four operations use the 32-step shift/subtract datapath (busy 33 cycles).
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int FUNW  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [FUNW-1:0]  funct,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [FUNW-1:0] FUN_MULT  = FUNW'(6'b011000);
  localparam logic [FUNW-1:0] FUN_MULTU = FUNW'(6'b011001);
  localparam logic [FUNW-1:0] FUN_DIV   = FUNW'(6'b011010);
  localparam logic [FUNW-1:0] FUN_DIVU  = FUNW'(6'b011011);
  localparam logic [FUNW-1:0] FUN_MTHI  = FUNW'(6'b010001);
  localparam logic [FUNW-1:0] FUN_MTLO  = FUNW'(6'b010011);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  // Multiply: {partial product high, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic               is_div_q;
  logic               neg_q;      // product / quotient must be negated
  logic               neg_rem_q;  // remainder takes the dividend's sign
  logic               divz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // Decode of the incoming request
  logic             is_mul_f, is_div_f, is_signed_f;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  always_comb begin
    is_mul_f    = (funct == FUN_MULT) || (funct == FUN_MULTU);
    is_div_f    = (funct == FUN_DIV)  || (funct == FUN_DIVU);
    is_signed_f = (funct == FUN_MULT) || (funct == FUN_DIV);
    a_neg       = is_signed_f & opA[WIDTH-1];
    b_neg       = is_signed_f & opB[WIDTH-1];
    // -x of the most negative value is itself, which is still the right unsigned magnitude
    abs_a       = a_neg ? -opA : opA;
    abs_b       = b_neg ? -opB : opB;
  end

`ifdef HILO_FAST_MULT_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  always_comb begin
    ext_a     = is_signed_f ? {{WIDTH{opA[WIDTH-1]}}, opA} : {{WIDTH{1'b0}}, opA};
    ext_b     = is_signed_f ? {{WIDTH{opB[WIDTH-1]}}, opB} : {{WIDTH{1'b0}}, opB};
    // Low 2*WIDTH bits of the extended product equal the exact signed/unsigned product
    fast_prod = ext_a * ext_b;
  end
`endif

  // One iteration of each datapath
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    // Shift the next dividend bit into the remainder and try subtracting the divisor;
    // a set borrow bit means the trial failed and the remainder is kept.
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    if (!div_trial[WIDTH]) begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end
  end

  // Sign fixup applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            if (funct == FUN_MTHI) begin
              hi_q <= opA;
            end else if (funct == FUN_MTLO) begin
              lo_q <= opA;
            end else if (is_mul_f || is_div_f) begin
              acc_q     <= {{WIDTH{1'b0}}, (is_div_f ? abs_a : abs_b)};
              opnd_q    <= is_div_f ? abs_b : abs_a;
              is_div_q  <= is_div_f;
              neg_q     <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              divz_q    <= is_div_f && (opB == '0);
              cnt_q     <= CNT_LAST;
              state_q   <= CALC;
`ifdef HILO_FAST_MULT_EN
              if (is_mul_f) begin
                acc_q   <= fast_prod;
                neg_q   <= 1'b0;
                state_q <= FIX;
              end
`endif
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= is_div_q ? div_next : mul_next;
            if (cnt_q == '0) begin
              state_q <= FIX;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!flush) begin
            done_q <= 1'b1;
            if (is_div_q) begin
              // Divide by zero: the restoring loop leaves |opA| as remainder, so the
              // sign fixup restores opA in HI; LO is forced to all ones.
              lo_q <= divz_q ? '1 : quo_fix;
              hi_q <= rem_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && start && !flush && (state_q == IDLE) && !is_mul_f && !is_div_f &&
        (funct != FUN_MTHI) && (funct != FUN_MTLO)) begin
      $warning("hilo_muldiv: start with unsupported funct %b ignored", funct);
    end
  end
`endif

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Testbench for hilo_muldiv: table of operations with expected HI/LO, a
// scoreboard queue popped on every done pulse, and hand-written sequences for
// MTHI/MTLO, start-while-busy, flush, invalid funct and asynchronous reset.
`timescale 1ns/1ps
module tb_hilo_muldiv;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
`ifdef HILO_FAST_MULT_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;
  localparam int NVEC = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [5:0]  funct;
  logic [31:0] opA, opB;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  hilo_muldiv #(.WIDTH(32), .FUNW(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .opA(opA), .opB(opB),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a, b, eh, el;
  } vec_t;

  typedef struct {
    logic [31:0] eh, el;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          busy_cnt = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  // Reference: native 64-bit arithmetic, truncating division
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb_;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    eh  = '0;
    el  = '0;
    case (f)
      F_MULTU: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      F_MULT:  begin p = sa * sb_; eh = p[63:32]; el = p[31:0]; end
      F_DIVU:  if (b == 0) begin el = '1; eh = a; end else begin el = a / b; eh = a % b; end
      F_DIV:   if (b == 0) begin el = '1; eh = a; end
               else begin el = 32'(sa / sb_); eh = 32'(sa % sb_); end
      default: ;
    endcase
  endfunction

  // Monitor: count busy cycles and compare each done pulse with the scoreboard head
  always @(negedge clk) begin : mon
    exp_t e;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        $display("done: hi=%08h lo=%08h busy_cycles=%0d (want %08h %08h %0d)",
                 hi, lo, busy_cnt, e.eh, e.el, e.cyc);
        check("hi", hi, e.eh);
        check("lo", lo, e.el);
        check("busy_cycles", 32'(busy_cnt), 32'(e.cyc));
      end
    end
    if (busy !== 1'b1 && done !== 1'b1) busy_cnt = 0;
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; funct = f; opA = a; opB = b;
    e.eh  = eh;
    e.el  = el;
    e.cyc = (f == F_MULT || f == F_MULTU) ? MUL_BUSY : DIV_BUSY;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; opA = $urandom; opB = $urandom;  // operands must not matter after acceptance
    mdl_hi = eh;
    mdl_lo = el;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check(name, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[NVEC];
    logic [5:0]  ops[4];
    logic [5:0]  rf;
    logic [31:0] ra, rb, reh, rel;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = '0; opA = '0; opB = '0;

    vecs[0] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{F_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[6] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{F_DIVU,  32'h00000064, 32'h00000003, 32'h00000001, 32'h00000021};
    vecs[9] = '{F_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};
    ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;
    for (int i = 10; i < NVEC; i++) begin
      rf = ops[i % 4];
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      model(rf, ra, rb, reh, rel);
      vecs[i] = '{rf, ra, rb, reh, rel};
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // Table-driven operations
    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);
      wait_drain("timeout_vec");
    end

    // MTHI then MTLO on consecutive cycles
    @(posedge clk); #1;
    start = 1'b1; funct = F_MTHI; opA = 32'h1234;
    @(posedge clk); #1;
    funct = F_MTLO; opA = 32'h5678;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi", hi, 32'h1234);
    check("mtlo_busy", 32'(busy), 32'd0);
    mdl_hi = 32'h1234; mdl_lo = 32'h5678;
    repeat (3) @(negedge clk);
    $display("seq: mthi/mtlo hi=%08h lo=%08h", hi, lo);

    // Unsupported funct is ignored
    @(posedge clk); #1;
    start = 1'b1; funct = 6'b100000; opA = 32'hFFFF; opB = 32'h3;
    @(posedge clk); #1;
    start = 1'b0;
    check("badf_busy", 32'(busy), 32'd0);
    check("badf_hi", hi, mdl_hi);
    check("badf_lo", lo, mdl_lo);

    // start and flush together in IDLE: flush wins
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct = F_MTHI; opA = 32'hBEEF;
    @(posedge clk); #1;
    check("flushstart_hi", hi, mdl_hi);
    funct = F_MULTU; opA = 32'h5; opB = 32'h5;
    @(posedge clk); #1;
    check("flushstart_busy", 32'(busy), 32'd0);
    start = 1'b0; flush = 1'b0;

    // DIVU 100/3, MTHI at cycle 5 ignored, flush at cycle 10
    @(posedge clk); #1;
    start = 1'b1; funct = F_DIVU; opA = 32'd100; opB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; funct = F_MTHI; opA = 32'hAAAA;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_mthi_hi", hi, mdl_hi);
    check("busy_mthi_busy", 32'(busy), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flushcalc_busy", 32'(busy), 32'd0);
    check("flushcalc_hi", hi, mdl_hi);
    check("flushcalc_lo", lo, mdl_lo);
    repeat (40) @(negedge clk);
    $display("seq: flush in CALC hi=%08h lo=%08h", hi, lo);

    // Flush during FIX: no write, no done
    @(posedge clk); #1;
    start = 1'b1; funct = F_DIVU; opA = 32'd1000; opB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("fix_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flushfix_busy", 32'(busy), 32'd0);
    check("flushfix_hi", hi, mdl_hi);
    check("flushfix_lo", lo, mdl_lo);
    repeat (5) @(negedge clk);
    $display("seq: flush in FIX hi=%08h lo=%08h", hi, lo);

    // start while busy (multiply and MT) is ignored; only the divide completes
    issue(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    start = 1'b1; funct = F_MULTU; opA = 32'd3; opB = 32'd3;
    @(posedge clk); #1;
    funct = F_MTLO; opA = 32'h7777;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain("timeout_busy_ignore");
    repeat (3) @(negedge clk);
    check("busy_ignore_busy", 32'(busy), 32'd0);
    check("busy_ignore_lo", lo, 32'd14);

    // Asynchronous reset at cycle 12 of a MULT
    @(posedge clk); #1;
    start = 1'b1; funct = F_MULT; opA = 32'h1234567; opB = 32'hFFFF0001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("seq: async reset hi=%08h lo=%08h", hi, lo);
    issue(F_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
    wait_drain("timeout_after_reset");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
